// File: rtl/multi_phase_signal_ctrl.sv
// ============================================================================
// multi_phase_signal_ctrl : round-robin N-approach signal controller
// Option macro SIG_MAXGREEN_EN enables max-green forced exit. Rev 1.0
// ============================================================================
`default_nettype none

module multi_phase_signal_ctrl #(
    parameter int N_PHASE     = 4,
    parameter int CNT_W       = 8,
    parameter int T_MIN_GREEN = 8,
    parameter int T_MAX_GREEN = 32,
    parameter int T_YELLOW    = 3,
    parameter int T_ALL_RED   = 2,
    localparam int PID_W      = (N_PHASE > 1) ? $clog2(N_PHASE) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_PHASE-1:0]     req,
    output logic [2*N_PHASE-1:0]   lamp,
    output logic [PID_W-1:0]       phase_id,
    output logic                   green_start
);

    typedef enum logic [1:0] {
        GREEN   = 2'd0,
        YELLOW  = 2'd1,
        ALL_RED = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_MIN_LAST = CNT_W'(T_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] C_MAX_LAST = CNT_W'(T_MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] C_Y_LAST   = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] C_AR_LAST  = CNT_W'(T_ALL_RED - 1);
`ifdef SIG_MAXGREEN_EN
    localparam bit C_MAXG_EN = 1'b1;
`else
    localparam bit C_MAXG_EN = 1'b0;
`endif

    state_t              r_state, w_state_n;
    logic [CNT_W-1:0]    r_cnt, w_cnt_n;
    logic [PID_W-1:0]    r_cur, w_cur_n;
    logic [PID_W-1:0]    r_nxt, w_nxt_n;
    logic [PID_W-1:0]    w_search;
    logic [N_PHASE-1:0]  r_pend, w_pend_n;
    logic [N_PHASE-1:0]  w_cur_oh;
    logic                r_gs, w_gs_n;
    logic                w_other;
    logic                w_min_ok;
    logic                w_maxg;

    // First pending index after c, wrapping; c itself is checked last.
    function automatic logic [PID_W-1:0] rr_search(
        input logic [N_PHASE-1:0] p,
        input logic [PID_W-1:0]   c
    );
        logic [PID_W-1:0] sel;
        logic [PID_W-1:0] pos;
        logic             found;
        int               idx;
        sel   = c;
        found = 1'b0;
        for (int k = 1; k <= N_PHASE; k++) begin
            idx = (int'(c) + k) % N_PHASE;
            pos = PID_W'(idx);
            if (!found && p[pos]) begin
                sel   = pos;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign w_cur_oh = N_PHASE'(1) << r_cur;
    assign w_other  = |(r_pend & ~w_cur_oh);
    assign w_min_ok = (r_cnt >= C_MIN_LAST);
    assign w_maxg   = C_MAXG_EN && (r_cnt >= C_MAX_LAST);
    assign w_search = rr_search(r_pend, r_cur);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= GREEN;
            r_cnt   <= '0;
            r_cur   <= '0;
            r_nxt   <= '0;
            r_pend  <= '0;
            r_gs    <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_cur   <= w_cur_n;
            r_nxt   <= w_nxt_n;
            r_pend  <= w_pend_n;
            r_gs    <= w_gs_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
        w_cur_n   = r_cur;
        w_nxt_n   = r_nxt;
        w_gs_n    = 1'b0;
        w_pend_n  = r_pend | req;
        case (r_state)
            GREEN: begin
                // The served phase never queues itself while it is green.
                w_pend_n[r_cur] = 1'b0;
                if (w_min_ok && w_other && (!req[r_cur] || w_maxg)) begin
                    w_state_n = YELLOW;
                    w_cnt_n   = '0;
                    w_nxt_n   = w_search;
                end
            end
            YELLOW: begin
                if (r_cnt == C_Y_LAST) begin
                    w_state_n = ALL_RED;
                    w_cnt_n   = '0;
                end
            end
            ALL_RED: begin
                if (r_cnt == C_AR_LAST) begin
                    w_state_n       = GREEN;
                    w_cnt_n         = '0;
                    w_cur_n         = r_nxt;
                    w_gs_n          = 1'b1;
                    w_pend_n[r_nxt] = 1'b0;
                end
            end
            default: begin
                w_state_n = GREEN;
                w_cnt_n   = '0;
            end
        endcase
    end

    generate
        for (genvar i = 0; i < N_PHASE; i++) begin : g_lamp
            assign lamp[2*i +: 2] = (r_cur != PID_W'(i)) ? 2'd0 :
                                    (r_state == GREEN)   ? 2'd2 :
                                    (r_state == YELLOW)  ? 2'd1 : 2'd0;
        end
    endgenerate

    assign phase_id    = r_cur;
    assign green_start = r_gs;

endmodule

`default_nettype wire

// File: tb/tb_multi_phase_signal_ctrl.sv
// Bench for multi_phase_signal_ctrl: vector table, directed corners, random vs model.
`default_nettype none

module tb_multi_phase_signal_ctrl;

    localparam int N    = 4;
    localparam int TMIN = 8;
    localparam int TMAX = 32;
    localparam int TY   = 3;
    localparam int TAR  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'h0;
    logic [7:0] lamp;
    logic [1:0] phase_id;
    logic       green_start;

    always #5 clk = ~clk;

    multi_phase_signal_ctrl #(
        .N_PHASE(N), .CNT_W(8), .T_MIN_GREEN(TMIN), .T_MAX_GREEN(TMAX),
        .T_YELLOW(TY), .T_ALL_RED(TAR)
    ) dut (
        .clk(clk), .rst(rst), .req(req),
        .lamp(lamp), .phase_id(phase_id), .green_start(green_start)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         n;
        logic [3:0] rq;
        logic [7:0] lamp;
        logic [1:0] pid;
        logic       gs;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string nm, input logic [7:0] el, input logic [1:0] ep, input logic eg);
        total++;
        if (lamp !== el || phase_id !== ep || green_start !== eg) begin
            bad++;
            $display("FAIL %s: got lamp=%h phase_id=%0d green_start=%b, want lamp=%h phase_id=%0d green_start=%b",
                     nm, lamp, phase_id, green_start, el, ep, eg);
        end
    endtask

    task automatic run(input int n, input logic [3:0] v);
        repeat (n) begin
            req = v;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Reference model: timestamps of green start / green end, pending set as flags.
    int       m_cur, m_nxt, m_now, m_gt, m_lt;
    bit       m_green, m_gs;
    bit [3:0] m_pend;

    function automatic void m_reset();
        m_cur = 0; m_nxt = 0; m_now = 0; m_gt = 0; m_lt = 0;
        m_green = 1'b1; m_gs = 1'b0; m_pend = 4'h0;
    endfunction

    function automatic logic [7:0] m_lamp();
        logic [7:0] l;
        l = 8'h00;
        for (int i = 0; i < N; i++) begin
            if (i == m_cur) begin
                if (m_green)               l[2*i +: 2] = 2'd2;
                else if (m_now - m_lt < TY) l[2*i +: 2] = 2'd1;
            end
        end
        return l;
    endfunction

    function automatic void m_step(input logic [3:0] r, input bit rs);
        bit [3:0] np;
        bit       other, exit_now, maxg;
        if (rs) begin
            m_reset();
            return;
        end
        np   = m_pend | r;
        m_gs = 1'b0;
        if (m_green) begin
            np[m_cur] = 1'b0;
            other = 1'b0;
            for (int j = 0; j < N; j++)
                if (j != m_cur && m_pend[j]) other = 1'b1;
`ifdef SIG_MAXGREEN_EN
            maxg = (m_now - m_gt) >= TMAX - 1;
`else
            maxg = 1'b0;
`endif
            exit_now = ((m_now - m_gt) >= TMIN - 1) && other && (!r[m_cur] || maxg);
            if (exit_now) begin
                for (int k = N; k >= 1; k--)
                    if (m_pend[(m_cur + k) % N]) m_nxt = (m_cur + k) % N;
                m_green = 1'b0;
                m_lt    = m_now + 1;
            end
        end else if (m_now - m_lt == TY + TAR - 1) begin
            m_cur      = m_nxt;
            m_green    = 1'b1;
            m_gt       = m_now + 1;
            m_gs       = 1'b1;
            np[m_nxt]  = 1'b0;
        end
        m_pend = np;
        m_now++;
    endfunction

    initial begin
        logic [3:0] hold, pulse, v;
        bit         rs;

        tbl[0]  = '{30, 4'h0, 8'h02, 2'd0, 1'b0};
        tbl[1]  = '{1,  4'h4, 8'h02, 2'd0, 1'b0};
        tbl[2]  = '{1,  4'h0, 8'h01, 2'd0, 1'b0};
        tbl[3]  = '{2,  4'h0, 8'h01, 2'd0, 1'b0};
        tbl[4]  = '{1,  4'h0, 8'h00, 2'd0, 1'b0};
        tbl[5]  = '{1,  4'h0, 8'h00, 2'd0, 1'b0};
        tbl[6]  = '{1,  4'h0, 8'h20, 2'd2, 1'b1};
        tbl[7]  = '{1,  4'h0, 8'h20, 2'd2, 1'b0};
        tbl[8]  = '{1,  4'hA, 8'h20, 2'd2, 1'b0};
        tbl[9]  = '{6,  4'h0, 8'h10, 2'd2, 1'b0};
        tbl[10] = '{5,  4'h0, 8'h80, 2'd3, 1'b1};
        tbl[11] = '{7,  4'h0, 8'h80, 2'd3, 1'b0};
        tbl[12] = '{1,  4'h0, 8'h40, 2'd3, 1'b0};
        tbl[13] = '{3,  4'h0, 8'h00, 2'd3, 1'b0};
        tbl[14] = '{1,  4'h0, 8'h00, 2'd3, 1'b0};
        tbl[15] = '{1,  4'h0, 8'h08, 2'd1, 1'b1};

        do_reset();
        chk("reset", 8'h02, 2'd0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            run(tbl[i].n, tbl[i].rq);
            chk($sformatf("vec%0d", i), tbl[i].lamp, tbl[i].pid, tbl[i].gs);
        end

        // Held request on the green phase with another phase waiting.
        do_reset();
        run(1, 4'b0011);
        run(30, 4'b0001);
        chk("maxg_c31", 8'h02, 2'd0, 1'b0);
        run(1, 4'b0001);
`ifdef SIG_MAXGREEN_EN
        chk("maxg_exit", 8'h01, 2'd0, 1'b0);
`else
        chk("maxg_hold", 8'h02, 2'd0, 1'b0);
        run(8, 4'b0001);
        chk("maxg_hold40", 8'h02, 2'd0, 1'b0);
        run(1, 4'b0000);
        chk("gapout", 8'h01, 2'd0, 1'b0);
`endif

        // Phase 0 re-requests during its own yellow.
        do_reset();
        run(1, 4'b0010);
        run(8, 4'b0000);
        chk("reserve_y", 8'h01, 2'd0, 1'b0);
        run(1, 4'b0001);
        run(3, 4'b0000);
        chk("reserve_p1", 8'h08, 2'd1, 1'b1);
        run(12, 4'b0000);
        chk("reserve_ar", 8'h00, 2'd1, 1'b0);
        run(1, 4'b0000);
        chk("reserve_p0", 8'h02, 2'd0, 1'b1);

        // Reset during all-red clears pending and timer.
        do_reset();
        run(1, 4'b0100);
        run(10, 4'b0000);
        chk("rst_ar_pre", 8'h00, 2'd0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_ar", 8'h02, 2'd0, 1'b0);
        run(20, 4'b0000);
        chk("rst_pend", 8'h02, 2'd0, 1'b0);
        run(1, 4'b0010);
        chk("rst_req", 8'h02, 2'd0, 1'b0);
        run(1, 4'b0000);
        chk("rst_exit", 8'h01, 2'd0, 1'b0);

        // Random traffic against the model.
        do_reset();
        m_reset();
        hold = 4'h0;
        for (int c = 0; c < 4000; c++) begin
            chk("rand", m_lamp(), 2'(m_cur), m_gs);
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 39) == 0) hold[b] = ~hold[b];
                pulse[b] = ($urandom_range(0, 9) == 0);
            end
            v   = hold | pulse;
            rs  = ($urandom_range(0, 499) == 0);
            req = v;
            rst = rs;
            m_step(v, rs);
            @(negedge clk);
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
